// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester front end for one shared multi-cycle ALU.
// Each accepted operation is registered onto the ALU operand outputs and
// held there. After ALU_LAT+1 cycles of execution the ALU result is
// captured into RSP_DATA, and the owning requester gets a one-cycle
// response pulse.
// Build option: define ALU_ARB_RR_EN for round-robin tie-breaking.
// Without it, requester 0 has fixed priority.
module alu_arbiter #(
  parameter int WIDTH   = 16,
  parameter int ALU_LAT = 1   // legal range 1..15
) (
  input  logic             CLK,
  input  logic             RST,       // asynchronous, active-low
  input  logic             REQ0_VLD,
  output logic             REQ0_RDY,
  input  logic [WIDTH-1:0] REQ0_A,
  input  logic [WIDTH-1:0] REQ0_B,
  input  logic [1:0]       REQ0_FUN,
  input  logic             REQ1_VLD,
  output logic             REQ1_RDY,
  input  logic [WIDTH-1:0] REQ1_A,
  input  logic [WIDTH-1:0] REQ1_B,
  input  logic [1:0]       REQ1_FUN,
  output logic             RSP0_VLD,
  output logic             RSP1_VLD,
  output logic [WIDTH:0]   RSP_DATA,
  output logic [WIDTH-1:0] ALU_A,
  output logic [WIDTH-1:0] ALU_B,
  output logic [1:0]       ALU_FUN,
  input  logic [WIDTH:0]   ALU_OUT,
  output logic             BUSY
);

  typedef enum logic {IDLE, EXEC} state_e;

  localparam logic [3:0] LAT_LD = 4'(ALU_LAT);

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             owner_q, owner_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [1:0]       alu_fun_q, alu_fun_d;
  logic [WIDTH:0]   rsp_data_q, rsp_data_d;
  logic             rsp0_vld_q, rsp0_vld_d;
  logic             rsp1_vld_q, rsp1_vld_d;
`ifdef ALU_ARB_RR_EN
  logic             last_q, last_d;   // requester granted most recently
`endif

  logic grant_idx;
  logic rdy0, rdy1;
  logic xfer;

  // Arbitration: pick a requester and raise its RDY only while idle and out of reset.
  always_comb begin
    // NOTE: every signal assigned in always_comb gets a default first; a
    // path that leaves one unassigned would infer a latch.
    grant_idx = 1'b0;
    if (REQ0_VLD && REQ1_VLD) begin
`ifdef ALU_ARB_RR_EN
      grant_idx = ~last_q;
`else
      grant_idx = 1'b0;
`endif
    end else begin
      grant_idx = REQ1_VLD;
    end
    rdy0 = RST && (state_q == IDLE) && REQ0_VLD && !grant_idx;
    rdy1 = RST && (state_q == IDLE) && REQ1_VLD &&  grant_idx;
    xfer = rdy0 || rdy1;
  end

  // Next-state logic: accept in IDLE, count down in EXEC, capture the result on the last EXEC cycle.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    owner_d    = owner_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_fun_d  = alu_fun_q;
    rsp_data_d = rsp_data_q;
    rsp0_vld_d = 1'b0;
    rsp1_vld_d = 1'b0;
`ifdef ALU_ARB_RR_EN
    last_d     = last_q;
`endif
    case (state_q)
      IDLE: begin
        if (xfer) begin
          state_d   = EXEC;
          cnt_d     = LAT_LD;
          owner_d   = grant_idx;
          alu_a_d   = grant_idx ? REQ1_A   : REQ0_A;
          alu_b_d   = grant_idx ? REQ1_B   : REQ0_B;
          alu_fun_d = grant_idx ? REQ1_FUN : REQ0_FUN;
`ifdef ALU_ARB_RR_EN
          last_d    = grant_idx;
`endif
        end
      end
      EXEC: begin
        if (cnt_q == 4'd0) begin
          state_d    = IDLE;
          rsp_data_d = ALU_OUT;
          rsp0_vld_d = !owner_q;
          rsp1_vld_d =  owner_q;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any operation in flight.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      // NOTE: the datapath registers are reset as well as the control state,
      // because the operand and result outputs must read zero during reset.
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      owner_q    <= 1'b0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_fun_q  <= 2'd0;
      rsp_data_q <= '0;
      rsp0_vld_q <= 1'b0;
      rsp1_vld_q <= 1'b0;
`ifdef ALU_ARB_RR_EN
      last_q     <= 1'b1;   // so the first tie goes to requester 0
`endif
    end else begin
      // NOTE: non-blocking assignments let every register sample the
      // pre-edge values, independent of statement order.
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      owner_q    <= owner_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_fun_q  <= alu_fun_d;
      rsp_data_q <= rsp_data_d;
      rsp0_vld_q <= rsp0_vld_d;
      rsp1_vld_q <= rsp1_vld_d;
`ifdef ALU_ARB_RR_EN
      last_q     <= last_d;
`endif
    end
  end

  assign REQ0_RDY = rdy0;
  assign REQ1_RDY = rdy1;
  assign RSP0_VLD = rsp0_vld_q;
  assign RSP1_VLD = rsp1_vld_q;
  assign RSP_DATA = rsp_data_q;
  assign ALU_A    = alu_a_q;
  assign ALU_B    = alu_b_q;
  assign ALU_FUN  = alu_fun_q;
  assign BUSY     = (state_q == EXEC);

endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter.
// A timeline reference model tracks grant cycles, the busy window and the
// scheduled response.
// Directed scenarios run first: single op, tie, back-to-back, width
// boundary, protocol withdrawal and reset mid-operation.
// A randomized phase follows.
module tb_alu_arbiter;

  localparam int W   = 16;
  localparam int LAT = 1;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0_vld, req1_vld, req0_rdy, req1_rdy;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [1:0]   req0_fun, req1_fun;
  logic         rsp0_vld, rsp1_vld, busy;
  logic [W:0]   rsp_data, alu_out;
  logic [W-1:0] alu_a, alu_b;
  logic [1:0]   alu_fun;

  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(W), .ALU_LAT(LAT)) dut (
    .CLK(clk), .RST(rst_n),
    .REQ0_VLD(req0_vld), .REQ0_RDY(req0_rdy), .REQ0_A(req0_a), .REQ0_B(req0_b), .REQ0_FUN(req0_fun),
    .REQ1_VLD(req1_vld), .REQ1_RDY(req1_rdy), .REQ1_A(req1_a), .REQ1_B(req1_b), .REQ1_FUN(req1_fun),
    .RSP0_VLD(rsp0_vld), .RSP1_VLD(rsp1_vld), .RSP_DATA(rsp_data),
    .ALU_A(alu_a), .ALU_B(alu_b), .ALU_FUN(alu_fun), .ALU_OUT(alu_out), .BUSY(busy)
  );

  function automatic logic [W:0] alu_f(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic [1:0] f);
    case (f)
      2'd0:    return {1'b0, a} + {1'b0, b};
      2'd1:    return {1'b0, a} - {1'b0, b};
      2'd2:    return {1'b0, a & b};
      default: return {1'b0, a | b};
    endcase
  endfunction

  // Shared ALU: registered, one cycle of latency.
  always @(posedge clk) alu_out <= alu_f(alu_a, alu_b, alu_fun);

  typedef struct {
    int         rem;    // operations still to issue with these operands
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [1:0]   fun;
  } req_t;

  req_t       req[2];
  bit         rst_plan;
  int         cyc = 0;
  int         total = 0;
  int         bad = 0;

  // Reference model: timeline of the last grant and the pending response.
  int         last_grant;
  int         free_at;
  int         rsp_at;
  bit         rsp_owner;
  bit         rr_last;
  logic [W:0] rsp_val, exp_data;
  logic [W-1:0] ea, eb;
  logic [1:0] ef;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    last_grant = -100;
    free_at    = 0;
    rsp_at     = -1;
    rr_last    = 1'b1;
    exp_data   = '0;
    ea         = '0;
    eb         = '0;
    ef         = 2'd0;
  endtask

  // One clock cycle: drive, predict, compare mid-cycle, then advance the model.
  task automatic step();
    bit v0, v1, gi, g, e_busy, e_r0, e_r1;
    @(posedge clk);
    #1;
    rst_n    = rst_plan;
    v0       = req[0].rem > 0;
    v1       = req[1].rem > 0;
    req0_vld = v0; req0_a = req[0].a; req0_b = req[0].b; req0_fun = req[0].fun;
    req1_vld = v1; req1_a = req[1].a; req1_b = req[1].b; req1_fun = req[1].fun;
    if (!rst_plan) model_reset();
    gi = 1'b0;
    g  = rst_plan && (cyc >= free_at) && (v0 || v1);
    if (g) begin
      if (v0 && v1) begin
`ifdef ALU_ARB_RR_EN
        gi = !rr_last;
`else
        gi = 1'b0;
`endif
      end else begin
        gi = v1;
      end
    end
    e_busy = rst_plan && (cyc > last_grant) && (cyc < free_at);
    e_r0   = rst_plan && (cyc == rsp_at) && !rsp_owner;
    e_r1   = rst_plan && (cyc == rsp_at) &&  rsp_owner;
    if (rst_plan && cyc == rsp_at) exp_data = rsp_val;
    @(negedge clk);
    check("rdy0",     32'(req0_rdy), 32'(g && !gi));
    check("rdy1",     32'(req1_rdy), 32'(g &&  gi));
    check("busy",     32'(busy),     32'(e_busy));
    check("rsp0_vld", 32'(rsp0_vld), 32'(e_r0));
    check("rsp1_vld", 32'(rsp1_vld), 32'(e_r1));
    check("rsp_data", 32'(rsp_data), 32'(exp_data));
    check("alu_a",    32'(alu_a),    32'(ea));
    check("alu_b",    32'(alu_b),    32'(eb));
    check("alu_fun",  32'(alu_fun),  32'(ef));
    if (g) begin
      last_grant = cyc;
      free_at    = cyc + LAT + 2;
      rsp_at     = free_at;
      rsp_owner  = gi;
      rsp_val    = alu_f(req[gi].a, req[gi].b, req[gi].fun);
      ea         = req[gi].a;
      eb         = req[gi].b;
      ef         = req[gi].fun;
      rr_last    = gi;
      req[gi].rem--;
    end
    cyc++;
  endtask

  task automatic set_req(input int i, input int n, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [1:0] f);
    req[i].rem = n; req[i].a = a; req[i].b = b; req[i].fun = f;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    rst_n = 1'b0;
    req0_vld = 1'b0; req1_vld = 1'b0;
    req0_a = '0; req0_b = '0; req0_fun = '0;
    req1_a = '0; req1_b = '0; req1_fun = '0;
    set_req(0, 0, '0, '0, 2'd0);
    set_req(1, 0, '0, '0, 2'd0);
    model_reset();

    // Reset state.
    rst_plan = 1'b0;
    run(3);
    rst_plan = 1'b1;
    run(2);

    // Single request: 3 + 165.
    set_req(0, 1, 16'd3, 16'd165, 2'd0);
    run(6);

    // Tie: both hold VLD for three operations each.
    set_req(0, 3, 16'd10, 16'd4, 2'd1);
    set_req(1, 3, 16'd12, 16'd10, 2'd2);
    run(24);
    set_req(0, 0, '0, '0, 2'd0);
    set_req(1, 0, '0, '0, 2'd0);
    run(4);

    // Back-to-back: REQ1 raises VLD in the cycle RSP0_VLD pulses.
    set_req(0, 1, 16'h0102, 16'h0304, 2'd3);
    run(3);
    set_req(1, 1, 16'h00F0, 16'h0F0F, 2'd2);
    run(6);

    // Width boundary: carry into bit WIDTH.
    set_req(1, 1, 16'hFFFF, 16'h0001, 2'd0);
    run(5);

    // Withdrawn VLD during EXEC must not be granted.
    set_req(0, 1, 16'h1234, 16'h0034, 2'd1);
    step();
    set_req(1, 1, 16'hAAAA, 16'h5555, 2'd3);
    step();
    set_req(1, 0, 16'hAAAA, 16'h5555, 2'd3);
    run(5);

    // Reset mid-operation.
    set_req(1, 1, 16'd1, 16'd2, 2'd3);
    step();
    rst_plan = 1'b0;
    run(2);
    rst_plan = 1'b1;
    run(4);
    set_req(0, 1, 16'd7, 16'd9, 2'd0);
    run(5);

    // Randomized traffic with occasional resets.
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < 2; i++) begin
        if (req[i].rem == 0 && $urandom_range(0, 2) == 0)
          set_req(i, 1, W'($urandom), W'($urandom), 2'($urandom_range(0, 3)));
      end
      rst_plan = ($urandom_range(0, 149) != 0);
      step();
    end
    rst_plan = 1'b1;
    run(12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
